// File: rtl/cpu_control_unit.sv
// Hardwired Moore control sequencer for the single-bus datapath: T0-T2 fetch,
// then T3-T7 execute microsteps decoded from IR, with memory-ready wait steps.
module cpu_control_unit #(
    parameter logic [4:0] OP_LD     = 5'b00000,
    parameter logic [4:0] OP_LDI    = 5'b00001,
    parameter logic [4:0] OP_ST     = 5'b00010,
    parameter logic [4:0] OP_ADD    = 5'b00011,
    parameter logic [4:0] OP_SUB    = 5'b00100,
    parameter logic [4:0] OP_AND    = 5'b01001,
    parameter logic [4:0] OP_OR     = 5'b01010,
    parameter logic [4:0] OP_ADDI   = 5'b01011,
    parameter logic [4:0] OP_BR     = 5'b10011,
    parameter logic [4:0] OP_JR     = 5'b10100,
    parameter logic [4:0] OP_HALT   = 5'b11011,
    parameter logic [4:0] ALU_ADD   = 5'd2,
    parameter logic [4:0] ALU_SUB   = 5'd3,
    parameter logic [4:0] ALU_AND   = 5'd4,
    parameter logic [4:0] ALU_OR    = 5'd5,
    parameter logic [4:0] ALU_INCPC = 5'd12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        ConOtp,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Cout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  OpCode,
    output logic        run,
    output logic        halted
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t state_q, state_d;
    logic   stop_q, stop_d;
    logic   first_q, first_d;

    logic [4:0] op;
    logic       is_alu, is_imm, is_ld, is_st, is_mem, is_br, is_jr, is_halt;
    logic [4:0] alu_code;
    logic       unused_ir;
    state_t     bnd;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_imm    = (op == OP_ADDI) || (op == OP_LDI);
    assign is_ld     = (op == OP_LD);
    assign is_st     = (op == OP_ST);
    assign is_mem    = is_ld || is_st;
    assign is_br     = (op == OP_BR);
    assign is_jr     = (op == OP_JR);
    assign is_halt   = (op == OP_HALT);

    always_comb begin
        alu_code = ALU_ADD;
        if (op == OP_SUB)      alu_code = ALU_SUB;
        else if (op == OP_AND) alu_code = ALU_AND;
        else if (op == OP_OR)  alu_code = ALU_OR;
    end

    // Stop seen this cycle counts too, so a stop on the last step still lands in IDLE.
    assign bnd = (stop_q || stop) ? S_IDLE : S_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = start ? S_T0 : S_IDLE;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = mem_rdy ? S_T2 : S_T1;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_halt)                                 state_d = S_HALT;
                else if (is_alu || is_imm || is_mem || is_br) state_d = S_T4;
                else                                         state_d = bnd;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_mem || is_br) ? S_T6 : bnd;
            S_T6: begin
                if (is_ld)      state_d = mem_rdy ? S_T7 : S_T6;
                else if (is_st) state_d = S_T7;
                else            state_d = bnd;
            end
            S_T7:   state_d = (is_st && !mem_rdy) ? S_T7 : bnd;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        stop_d  = (state_q == S_IDLE) ? (start && stop) : (stop_q || stop);
        first_d = (state_q == S_T0);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; CONin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; Read = 1'b0; Write = 1'b0; OpCode = 5'd0;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = ALU_INCPC; end
            S_T1: begin
                // PC latches Z only on the first T1 cycle so waits cannot re-increment it.
                Zlowout = first_q; PCin = first_q; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_alu || op == OP_ADDI) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (op == OP_LDI || is_mem) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                else if (is_br) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                else if (is_jr) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            end
            S_T4: begin
                if (is_alu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = alu_code; end
                else if (is_imm || is_mem) begin Cout = 1'b1; Zin = 1'b1; OpCode = ALU_ADD; end
                else if (is_br) begin PCout = 1'b1; Yin = 1'b1; end
            end
            S_T5: begin
                if (is_alu || is_imm) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_mem) begin Zlowout = 1'b1; MARin = 1'b1; end
                else if (is_br) begin Cout = 1'b1; Zin = 1'b1; OpCode = ALU_ADD; end
            end
            S_T6: begin
                if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
                else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                else if (is_br) begin Zlowout = ConOtp; PCin = ConOtp; end
            end
            S_T7: begin
                if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_st) Write = 1'b1;
            end
            default: ;
        endcase
        run    = (state_q != S_IDLE) && (state_q != S_HALT);
        halted = (state_q == S_HALT);
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized scoreboard bench: a per-instruction microstep table expands into
// expected per-cycle output vectors that a monitor compares at every negedge.
module tb_cpu_control_unit;
  logic clk = 1'b0, clr, start, stop, ConOtp, mem_rdy;
  logic [31:0] ir;
  logic PCout, Zlowout, MDRout, BAout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, Read, Write, run, halted;
  logic [4:0] OpCode;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .ir(ir), .ConOtp(ConOtp),
    .mem_rdy(mem_rdy), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout),
    .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Read(Read), .Write(Write), .OpCode(OpCode), .run(run), .halted(halted)
  );

  wire [25:0] act = {PCout, Zlowout, MDRout, BAout, Cout, MARin, Zin, PCin, MDRin, IRin,
                     Yin, CONin, Gra, Grb, Grc, Rin, Rout, Read, Write, OpCode, run, halted};

  localparam logic [18:0] PCOUT = 19'h40000, ZLOW = 19'h20000, MDROUT = 19'h10000,
    BAOUT = 19'h08000, COUT = 19'h04000, MARIN = 19'h02000, ZIN = 19'h01000,
    PCIN = 19'h00800, MDRIN = 19'h00400, IRIN = 19'h00200, YIN = 19'h00100,
    CONIN = 19'h00080, GRA = 19'h00040, GRB = 19'h00020, GRC = 19'h00010,
    RIN = 19'h00008, ROUT = 19'h00004, READ = 19'h00002, WRITE = 19'h00001;

  typedef struct { logic [25:0] vec; logic rdy; } cyc_t;
  cyc_t        plan_q[$];
  logic [25:0] exp_q[$];
  int          n_cmp = 0, n_bad = 0, n_mon = 0;
  bit          sflag = 0, idle_now = 1;

  function automatic logic [25:0] v(logic [18:0] m, logic [4:0] alu, bit r, bit h);
    return {m, alu, r, h};
  endfunction

  function automatic logic [25:0] ex(logic [18:0] m, logic [4:0] alu);
    return v(m, alu, 1'b1, 1'b0);
  endfunction

  task automatic add1(input logic [25:0] vec, input logic rdy);
    cyc_t c;
    c.vec = vec; c.rdy = rdy;
    plan_q.push_back(c);
  endtask

  task automatic addr(input logic [25:0] vec);
    add1(vec, 1'($urandom_range(0, 1)));
  endtask

  task automatic addw(input logic [25:0] vec, input int n);
    for (int i = 0; i <= n; i++) add1(vec, i == n);
  endtask

  // Expected microsteps, straight from the instruction table.
  task automatic plan(input logic [4:0] op, input bit con, input int w1, input int w2);
    plan_q.delete();
    addr(ex(PCOUT | MARIN | ZIN, 5'd12));
    for (int i = 0; i <= w1; i++)
      add1(ex(i == 0 ? (ZLOW | PCIN | READ | MDRIN) : (READ | MDRIN), 5'd0), i == w1);
    addr(ex(MDROUT | IRIN, 5'd0));
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
        addr(ex(GRB | ROUT | YIN, 5'd0));
        addr(ex(GRC | ROUT | ZIN, op == 5'b00011 ? 5'd2 : op == 5'b00100 ? 5'd3 :
                                  op == 5'b01001 ? 5'd4 : 5'd5));
        addr(ex(ZLOW | GRA | RIN, 5'd0));
      end
      5'b01011, 5'b00001: begin
        addr(ex(op == 5'b01011 ? (GRB | ROUT | YIN) : (GRB | BAOUT | YIN), 5'd0));
        addr(ex(COUT | ZIN, 5'd2));
        addr(ex(ZLOW | GRA | RIN, 5'd0));
      end
      5'b00000, 5'b00010: begin
        addr(ex(GRB | BAOUT | YIN, 5'd0));
        addr(ex(COUT | ZIN, 5'd2));
        addr(ex(ZLOW | MARIN, 5'd0));
        if (op == 5'b00000) begin
          addw(ex(READ | MDRIN, 5'd0), w2);
          addr(ex(MDROUT | GRA | RIN, 5'd0));
        end else begin
          addr(ex(GRA | ROUT | MDRIN, 5'd0));
          addw(ex(WRITE, 5'd0), w2);
        end
      end
      5'b10011: begin
        addr(ex(GRA | ROUT | CONIN, 5'd0));
        addr(ex(PCOUT | YIN, 5'd0));
        addr(ex(COUT | ZIN, 5'd2));
        addr(ex(con ? (ZLOW | PCIN) : 19'd0, 5'd0));
      end
      5'b10100: addr(ex(GRA | ROUT | PCIN, 5'd0));
      default:  addr(ex(19'd0, 5'd0));
    endcase
  endtask

  task automatic check(input logic [25:0] got, input logic [25:0] want, input string nm);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [25:0] e;
      e = exp_q.pop_front();
      n_mon++;
      check(act, e, $sformatf("cycle%0d", n_mon));
    end
  end

  task automatic cycle(input logic [25:0] vec, input logic rdy, input logic s, input logic p);
    @(posedge clk);
    #1;
    start = s; stop = p; mem_rdy = rdy;
    exp_q.push_back(vec);
  endtask

  task automatic enter_idle();
    bit st;
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) cycle(26'd0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    st = ($urandom_range(0, 3) == 0);
    cycle(26'd0, 1'($urandom_range(0, 1)), 1'b1, st);
    sflag = st;
    idle_now = 0;
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #2 clr = 1'b0;
    #1 check(act, 26'd0, nm);
    cycle(26'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    idle_now = 1;
    sflag = 0;
  endtask

  task automatic exec(input logic [31:0] irv, input bit con, input int w1, input int w2,
                      input int abort_at);
    bit st;
    plan(irv[31:27], con, w1, w2);
    if (idle_now) enter_idle();
    for (int i = 0; i < plan_q.size(); i++) begin
      st = ($urandom_range(0, 23) == 0);
      @(posedge clk);
      #1;
      if (i == 0) begin ir = irv; ConOtp = con; end
      start = 1'($urandom_range(0, 1)); stop = st; mem_rdy = plan_q[i].rdy;
      exp_q.push_back(plan_q[i].vec);
      sflag = sflag | st;
      if (i == abort_at) begin
        async_reset("reset_mid_wait");
        return;
      end
    end
    idle_now = sflag;
    sflag = 0;
  endtask

  logic [4:0] ops[14] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01001,
                          5'b01010, 5'b01011, 5'b10011, 5'b10100, 5'b00101, 5'b11111,
                          5'b01100, 5'b10000};

  initial begin
    clr = 1'b0; start = 1'b0; stop = 1'b0; ir = 32'd0; ConOtp = 1'b0; mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) cycle(26'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) cycle(26'd0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    idle_now = 1;

    exec(32'h18918000, 1'b0, 0, 0, -1);
    exec(32'h9B080019, 1'b1, 0, 0, -1);
    exec(32'h9B080019, 1'b0, 0, 0, -1);
    exec(32'h00800000, 1'b0, 3, 3, -1);
    exec(32'h10800000, 1'b0, 0, 0, -1);
    for (int k = 0; k < 60; k++) begin
      logic [4:0] o;
      o = ops[$urandom_range(0, 13)];
      exec({o, 27'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $urandom_range(0, 3), -1);
    end
    exec(32'h00800000, 1'b0, 1, 6, 1 + 2 + 1 + 3 + 2);
    exec(32'hD8000000, 1'b0, 0, 0, -1);
    for (int i = 0; i < 6; i++)
      cycle(v(19'd0, 5'd0, 1'b0, 1'b1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    async_reset("reset_from_halt");
    for (int i = 0; i < 2; i++) cycle(26'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
